// File: rtl/toy_bus_ack_order_sched.sv
// Purpose: ordering scheduler for a 1-in/2-out decode node; records each accepted request's target and grants acks in request order.
// Latency: request path is combinational (zero cycles); ack grant follows the registered FIFO head, and an ack can be accepted no earlier than 1 cycle after its request fires.
// Backpressure: requests stall while DEPTH requests are outstanding; a non-head target's ack is held off (rdy=0) until that target reaches the head.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   up_req_vld/up_req_rdy         upstream request handshake
//   req_tgt                       decoded target of the current request (0=out0, 1=out1)
//   dec_req_vld/dec_req_rdy       gated request handshake toward the decoder
//   out0_ack_vld/out0_ack_rdy     ack handshake with target 0
//   out1_ack_vld/out1_ack_rdy     ack handshake with target 1
//   up_ack_vld/up_ack_rdy         ordered ack handshake toward upstream
//   ack_sel                       payload mux select for the upstream ack (head target)
//   outstanding                   requests in flight (order-FIFO occupancy)
//   err_unexp_ack                 sticky flag: ack seen from a target with nothing outstanding
module toy_bus_ack_order_sched #(
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_req_vld,
  output logic             up_req_rdy,
  input  logic             req_tgt,
  output logic             dec_req_vld,
  input  logic             dec_req_rdy,
  input  logic             out0_ack_vld,
  output logic             out0_ack_rdy,
  input  logic             out1_ack_vld,
  output logic             out1_ack_rdy,
  output logic             up_ack_vld,
  input  logic             up_ack_rdy,
  output logic             ack_sel,
  output logic [CNT_W-1:0] outstanding,
  output logic             err_unexp_ack
);

  localparam int PTR_W = $clog2(DEPTH);

  // One bit per entry is enough: it holds the target of that request.
  logic [DEPTH-1:0] fifo_q, fifo_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic             err_q, err_d;

  logic full, empty, head, push, pop;

  // Full/empty come from registered occupancy only, so a pop never frees a
  // slot for a same-cycle push and a same-cycle push never reaches the head.
  assign full  = (outst_q == CNT_W'(DEPTH));
  assign empty = (outst_q == '0);
  assign head  = fifo_q[rd_q];

  assign dec_req_vld = up_req_vld & ~full;
  assign up_req_rdy  = dec_req_rdy & ~full;
  assign push        = up_req_vld & dec_req_rdy & ~full;

  assign ack_sel      = ~empty & head;
  assign up_ack_vld   = ~empty & (head ? out1_ack_vld : out0_ack_vld);
  assign out0_ack_rdy = ~empty & ~head & up_ack_rdy;
  assign out1_ack_rdy = ~empty & head & up_ack_rdy;
  assign pop          = up_ack_vld & up_ack_rdy;

  assign outstanding   = outst_q;
  assign err_unexp_ack = err_q;

  always_comb begin
    fifo_d = fifo_q;
    if (push) begin
      fifo_d[wr_q] = req_tgt;
    end
    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    wr_d    = wr_q + PTR_W'(push);
    rd_d    = rd_q + PTR_W'(pop);
    outst_d = outst_q + CNT_W'(push) - CNT_W'(pop);
    cnt0_d  = cnt0_q + CNT_W'(push & ~req_tgt) - CNT_W'(pop & ~head);
    cnt1_d  = cnt1_q + CNT_W'(push & req_tgt) - CNT_W'(pop & head);
    // Judged against registered per-target counts: an ack valid in the same
    // cycle as that target's first request is reported as unexpected.
    err_d   = err_q
            | (out0_ack_vld & (cnt0_q == '0))
            | (out1_ack_vld & (cnt1_q == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      outst_q <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      fifo_q  <= fifo_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      outst_q <= outst_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      err_q   <= err_d;
    end
  end

  a_cnt_sum: assert property (@(posedge clk) disable iff (rst)
    (cnt0_q + cnt1_q) == outst_q);
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    !(pop && empty));

endmodule
